// File: rtl/ex_div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer: operand width,
// iteration counter width, divide-group op encodings and FSM states.
package ex_div_ctrl_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;

  // funct3[1:0] of the divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_CORR = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // DIV and REM are the signed variants (funct3[0] == 0)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (funct3[1] == 1)
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// One restoring division iteration, purely combinational.
// The shifted partial remainder is kept one bit wider than XLEN so that
// divisors with the top bit set (unsigned ops) still compare correctly.
module ex_div_ctrl_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    shifted = {rem_in, dvd_msb};
    diff    = shifted - {1'b0, divisor};
    // rem_in < divisor always, so the difference fits in XLEN bits when
    // no borrow occurred; a set top bit therefore means shifted < divisor.
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU next to the EX ALU.
// Runs a 32-iteration restoring divide on operand magnitudes, fixes the
// signs in a correction cycle, and presents the result for one cycle.
// Note: the reset input is named rstn but is active-high.
// Optional build macro DIV_EARLY_TERM_EN: skip the iterations when
// |dividend| < |divisor| (quotient 0, remainder |dividend|).
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on acceptance
// CALC  | one restoring step per cycle, 32 cycles
// CORR  | sign correction of quotient/remainder, result registered
// DONE  | valid_o/regs_wen_o strobe for one cycle
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            regs_wen_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [4:0]       rd_q;
  logic             rem_sel_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic            sgn_op;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] abs_dvd;
  logic [XLEN-1:0] abs_dvs;
  logic            dvs_zero;
  logic            ovf;
  logic            early;
  logic            accept;

  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Operand classification for the request presented in IDLE
  always_comb begin
    sgn_op   = op_is_signed(op_i);
    dvd_neg  = sgn_op & dividend_i[XLEN-1];
    dvs_neg  = sgn_op & divisor_i[XLEN-1];
    abs_dvd  = dvd_neg ? -dividend_i : dividend_i;
    abs_dvs  = dvs_neg ? -divisor_i : divisor_i;
    dvs_zero = (divisor_i == '0);
    ovf      = sgn_op & (dividend_i == INT_MIN) & (divisor_i == '1);
`ifdef DIV_EARLY_TERM_EN
    early    = ~dvs_zero & (abs_dvd < abs_dvs);
`else
    early    = 1'b0;
`endif
    accept   = (state_q == ST_IDLE) & start_i & ~flush_i;
  end

  ex_div_ctrl_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[XLEN-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign correction applied in CORR (flags are zero for unsigned ops)
  always_comb begin
    quo_fix = q_neg_q ? -quo_q : quo_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
  end

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state and pipeline-facing control outputs
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    busy_o     = (state_q != ST_IDLE);
    // A flush in the DONE cycle cancels the write-back as well.
    valid_o    = (state_q == ST_DONE) & ~flush_i;
    regs_wen_o = valid_o;
    case (state_q)
      ST_IDLE: begin
        stall_o = start_i;
        if (start_i) begin
          if (dvs_zero || ovf) state_d = ST_DONE;
          else if (early)      state_d = ST_CORR;
          else                 state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        stall_o = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_CORR;
      end
      ST_CORR: begin
        stall_o = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      rd_q      <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rem_sel_q <= op_is_rem(op_i);
            rd_q      <= rd_addr_i;
            q_neg_q   <= dvd_neg ^ dvs_neg;
            r_neg_q   <= dvd_neg;
            dvd_q     <= abs_dvd;
            dvs_q     <= abs_dvs;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            // Special cases bypass CORR, so the result is registered here.
            if (dvs_zero) begin
              quo_q     <= '1;
              rem_q     <= dividend_i;
              result_o  <= op_is_rem(op_i) ? dividend_i : '1;
              rd_addr_o <= rd_addr_i;
            end else if (ovf) begin
              quo_q     <= INT_MIN;
              result_o  <= op_is_rem(op_i) ? '0 : INT_MIN;
              rd_addr_o <= rd_addr_i;
            end else if (early) begin
              rem_q <= abs_dvd;
            end
          end
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_q};
          dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_CORR: begin
          if (!flush_i) begin
            quo_q     <= quo_fix;
            rem_q     <= rem_fix;
            result_o  <= rem_sel_q ? rem_fix : quo_fix;
            rd_addr_o <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: a table of directed divide vectors
// run back to back, plus sequences for flush, ignored start and reset.
module tb_ex_div_ctrl;
  import ex_div_ctrl_pkg::*;

`ifdef DIV_EARLY_TERM_EN
  localparam int LAT_LT = 2;
`else
  localparam int LAT_LT = 34;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, valid_o, regs_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_div_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .regs_wen_o (regs_wen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; start is presented in that cycle (cycle 0)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                        input string tag);
    int cyc;
    int stall_bad;
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    #1 chk({tag, " stall_c0"}, 32'(stall_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    stall_bad = 0;
    while (!valid_o && cyc < 60) begin
      if (!stall_o || !busy_o) stall_bad++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
    chk({tag, " rd"}, 32'(rd_addr_o), 32'(rd));
    chk({tag, " wen"}, 32'(regs_wen_o), 32'd1);
    chk({tag, " stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, " stall_gaps"}, 32'(stall_bad), 32'd0);
    @(negedge clk);
    chk({tag, " valid_1cyc"}, 32'(valid_o), 32'd0);
    chk({tag, " idle_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int vcnt;
    logic [31:0] seen_res;
    logic [4:0]  seen_rd;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         34});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          34});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  34});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  34});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          5'd5,  32'hFFFF_FFFF,  1});
    vecs.push_back('{OP_REM,  32'd5,          32'd0,          5'd6,  32'd5,          1});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd9,  32'hFFFF_FFFB,  1});
    vecs.push_back('{OP_DIV,  32'd100,        32'hFFFF_FFF9,  5'd10, 32'hFFFF_FFF2,  34});
    vecs.push_back('{OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd11, 32'd2,          34});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  5'd12, 32'd1,          34});
    vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  5'd13, 32'h7FFF_FFFF,  34});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd2,          5'd14, 32'hC000_0000,  34});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'd3,          5'd15, 32'hFFFF_FFFE,  34});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd16, 32'hFFFF_FFFF,  34});
    vecs.push_back('{OP_DIVU, 32'd3,          32'd10,         5'd17, 32'd0,          LAT_LT});
    vecs.push_back('{OP_REMU, 32'd3,          32'd10,         5'd18, 32'd3,          LAT_LT});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFD,  32'd10,         5'd19, 32'hFFFF_FFFD,  LAT_LT});
    vecs.push_back('{OP_DIVU, 32'd0,          32'd5,          5'd20, 32'd0,          LAT_LT});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst wen", 32'(regs_wen_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    chk("rst rd", 32'(rd_addr_o), 32'd0);
    rstn = 1'b0;
    @(negedge clk);

    // Table vectors, issued back to back (start in the cycle after DONE)
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Flush at cycle 10 of DIVU 1000/3
    op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd21; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    vcnt = 0;
    repeat (9) begin
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush busy_c11", 32'(busy_o), 32'd0);
    repeat (40) begin
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    chk("flush no_valid", 32'(vcnt), 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, 34, "post_flush");

    // start_i pulsed at cycle 5 of a running op is ignored
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    vcnt = 0;
    seen_res = '0;
    seen_rd = '0;
    for (int c = 1; c < 60; c++) begin
      if (c == 5) begin
        op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd4; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (valid_o) begin
        vcnt++;
        seen_res = result_o;
        seen_rd = rd_addr_o;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("ign_start valid_count", 32'(vcnt), 32'd1);
    chk("ign_start result", seen_res, 32'd14);
    chk("ign_start rd", 32'(seen_rd), 32'd3);

    // Reset asserted at cycle 20 of an operation
    op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd7; rd_addr_i = 5'd23; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    chk("midrst busy_before", 32'(busy_o), 32'd1);
    rstn = 1'b1;
    #1;
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst stall", 32'(stall_o), 32'd0);
    chk("midrst valid", 32'(valid_o), 32'd0);
    chk("midrst result", result_o, 32'd0);
    chk("midrst rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    vcnt = 0;
    repeat (40) begin
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    chk("midrst no_valid", 32'(vcnt), 32'd0);
    run_op(OP_REMU, 32'd1000, 32'd7, 5'd24, 32'd6, 34, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
